// File: rtl/sr_pkg.sv
// -----------------------------------------------------------------------------
// sr_pkg
// Definitions shared by the SR drive controller and the SR flip-flop benches.
//   sr_state_e  : drive FSM states
//   PULSE_CNT_W : width of the S/R pulse-length counter
// -----------------------------------------------------------------------------
package sr_pkg;

    localparam int unsigned PULSE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_S = 2'd1,
        DRIVE_R = 2'd2,
        GUARD   = 2'd3
    } sr_state_e;

endpackage

// File: rtl/sr_debounce.sv
// -----------------------------------------------------------------------------
// sr_debounce
// Brings one raw pushbutton into the clk domain, debounces it and emits a
// one-cycle press request on each rising edge of the debounced level.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   i_btn   : raw asynchronous button, active high
//   o_press : combinational one-cycle press request (debounced rising edge)
// -----------------------------------------------------------------------------
module sr_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       r_sync;
    logic             r_level;
    logic             r_level_prev;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= 2'b00;
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_sync       <= {r_sync[0], i_btn};
            r_level_prev <= r_level;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // N-th consecutive differing edge: accept the new level
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_level & ~r_level_prev;

endmodule

// File: rtl/sr_drive_controller.sv
// -----------------------------------------------------------------------------
// sr_drive_controller
// Turns debounced set/reset button presses into clean, mutually exclusive S/R
// pulses for the gated SR flip-flop stage, with one guard cycle between pulses.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   set_btn   : raw set button, asynchronous, active high
//   reset_btn : raw reset button, asynchronous, active high
//   s, r      : S/R drive, decoded from the registered FSM state
//   busy      : FSM not in IDLE
//   q_shadow  : expected flip-flop Q
//   drop      : one-cycle pulse, registered, when a press is discarded
// -----------------------------------------------------------------------------
module sr_drive_controller
    import sr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic q_shadow,
    output logic drop
);

    localparam logic [PULSE_CNT_W-1:0] PULSE_LOAD = PULSE_CNT_W'(PULSE_CYCLES - 1);

    logic                   w_set_req;
    logic                   w_rst_req;
    sr_state_e              r_state;
    sr_state_e              w_state_nxt;
    logic [PULSE_CNT_W-1:0] r_cnt;
    logic [PULSE_CNT_W-1:0] w_cnt_nxt;
    logic                   r_q;
    logic                   w_q_nxt;
    logic                   r_drop;
    logic                   w_drop_nxt;

    sr_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (set_btn),
        .o_press(w_set_req)
    );

    sr_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_rst_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (reset_btn),
        .o_press(w_rst_req)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_drop_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_set_req && w_rst_req) begin
                    // Conflicting presses: neither wins
                    w_drop_nxt = 1'b1;
                end else if (w_set_req) begin
                    w_state_nxt = DRIVE_S;
                    w_cnt_nxt   = PULSE_LOAD;
                    w_q_nxt     = 1'b1;
                end else if (w_rst_req) begin
                    w_state_nxt = DRIVE_R;
                    w_cnt_nxt   = PULSE_LOAD;
                    w_q_nxt     = 1'b0;
                end
            end
            DRIVE_S, DRIVE_R: begin
                w_drop_nxt = w_set_req | w_rst_req;
                if (r_cnt == '0) begin
                    w_state_nxt = GUARD;
                end else begin
                    w_cnt_nxt = r_cnt - PULSE_CNT_W'(1);
                end
            end
            GUARD: begin
                w_drop_nxt  = w_set_req | w_rst_req;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Decoded from the state register only, so s and r can never overlap
    assign s        = (r_state == DRIVE_S);
    assign r        = (r_state == DRIVE_R);
    assign busy     = (r_state != IDLE);
    assign q_shadow = r_q;
    assign drop     = r_drop;

endmodule
